// File: rtl/cache_miss_handler_pkg.sv
// cache_miss_handler_pkg: miss-handler state encoding, cache geometry (INDEX_W, TAG_W, WAYS) and address-field slice bounds
package cache_miss_handler_pkg;
  localparam int INDEX_W = 8;
  localparam int TAG_W = 22;
  localparam int WAYS = 4;
  localparam int WAY_W = $clog2(WAYS);
  localparam int OFF_W = 2;
  localparam int IDX_LSB = OFF_W;
  localparam int IDX_MSB = IDX_LSB + INDEX_W - 1;
  localparam int TAG_LSB = IDX_MSB + 1;
  localparam int TAG_MSB = TAG_LSB + TAG_W - 1;
  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL, FILL, DONE} state_t;
endpackage

// File: rtl/cache_miss_handler.sv
// cache_miss_handler: blocking miss FSM; cpu_* request/ready/stall, hit+victim_* from tags, mem_* writeback/refill port, fill_* line write, lru_update pulse, hit_cnt/miss_cnt stats
module cache_miss_handler
  import cache_miss_handler_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_stall,
  input  logic              hit,
  input  logic [WAY_W-1:0]  victim_way,
  input  logic              victim_valid,
  input  logic              victim_dirty,
  input  logic [TAG_W-1:0]  victim_tag,
  input  logic [DATA_W-1:0] victim_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_we,
  output logic [WAY_W-1:0]  fill_way,
  output logic [INDEX_W-1:0] fill_index,
  output logic [TAG_W-1:0]  fill_tag,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_dirty,
  output logic              lru_update,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  state_t state, nxt;
  logic [ADDR_W-1:OFF_W] addr_q;
  logic we_q;
  logic [DATA_W-1:0] wdata_q, vdata_q, rdata_q;
  logic [WAY_W-1:0] way_q;
  logic [TAG_W-1:0] vtag_q;
  logic idle, idle_hit, idle_miss;
  logic unused;
  assign unused = ^cpu_addr[OFF_W-1:0];
  assign idle = state == IDLE;
  assign idle_hit = idle && cpu_req && hit;
  assign idle_miss = idle && cpu_req && !hit;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = !idle_miss ? IDLE : (victim_valid && victim_dirty) ? WRITEBACK : cpu_we ? FILL : REFILL;
      WRITEBACK: nxt = !mem_ready ? WRITEBACK : we_q ? FILL : REFILL;
      REFILL:    nxt = mem_ready ? FILL : REFILL;
      FILL:      nxt = DONE;
      DONE:      nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end
  always_comb begin
    cpu_ready = idle_hit || state == DONE;
    cpu_stall = state == WRITEBACK || state == REFILL || state == FILL;
    mem_req = state == WRITEBACK || state == REFILL;
    mem_we = state == WRITEBACK;
    mem_addr = mem_we ? {vtag_q, addr_q[IDX_MSB:IDX_LSB], {OFF_W{1'b0}}} : {addr_q, {OFF_W{1'b0}}};
    mem_wdata = vdata_q;
    fill_we = (idle_hit && cpu_we) || state == FILL;
    lru_update = idle_hit || state == FILL;
    fill_way = idle ? victim_way : way_q;
    fill_index = idle ? cpu_addr[IDX_MSB:IDX_LSB] : addr_q[IDX_MSB:IDX_LSB];
    fill_tag = idle ? cpu_addr[TAG_MSB:TAG_LSB] : addr_q[TAG_MSB:TAG_LSB];
    fill_data = idle ? cpu_wdata : we_q ? wdata_q : rdata_q;
    fill_dirty = idle ? 1'b1 : we_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      we_q <= 1'b0;
      wdata_q <= '0;
      vdata_q <= '0;
      rdata_q <= '0;
      way_q <= '0;
      vtag_q <= '0;
      hit_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (idle_miss) begin
        addr_q <= cpu_addr[ADDR_W-1:OFF_W];
        we_q <= cpu_we;
        wdata_q <= cpu_wdata;
        vdata_q <= victim_data;
        way_q <= victim_way;
        vtag_q <= victim_tag;
      end
      if (state == REFILL && mem_ready) rdata_q <= mem_rdata;
      if (idle_hit) hit_cnt <= hit_cnt + 32'd1;
      if (idle_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
endmodule
